// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and scheduler state type.
package vga_timing_pkg;

  localparam int VERTICAL_MAX         = 628;
  localparam int VERTICAL_BLANK_START = 600;
  localparam int HORIZONTAL_MAX       = 1056;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_GRANT = 2'd2
  } sched_state_t;

  // First line on which a new grant may no longer start.
  function automatic logic [10:0] grant_line_limit(input int guard_lines);
    return 11'(VERTICAL_MAX - guard_lines);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above the pointer,
// wrapping to the lowest requester when none are above it.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    pointer,
  output logic [N_REQ-1:0] pick,
  output logic             valid
);

  logic [N_REQ-1:0] hi_mask;
  logic [N_REQ-1:0] hi_req;
  logic [N_REQ-1:0] sel;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_mask
      assign hi_mask[gi] = (PW'(gi) >= pointer);
    end
  endgenerate

  // Prefer requesters at/after the pointer, isolate the lowest set bit.
  always_comb begin
    hi_req = req & hi_mask;
    sel    = (|hi_req) ? hi_req : req;
    pick   = sel & (~sel + N_REQ'(1));
    valid  = |req;
  end

endmodule

// File: rtl/vblank_scheduler.sv
// Grants frame-memory access to one requester at a time during vertical
// blanking, with round-robin fairness, a guard band before active video,
// a per-grant timeout and revocation when blanking ends.
module vblank_scheduler
  import vga_timing_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int GUARD_LINES   = 2,
  parameter int MAX_GRANT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vblnk,
  input  logic [10:0]      vcount,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             frame_tick,
  output logic [N_REQ-1:0] timeout_err,
  output logic             overrun
);

  localparam int              PW         = $clog2(N_REQ);
  localparam int              CW         = $clog2(MAX_GRANT_CYC);
  localparam logic [10:0]     LINE_LIMIT = grant_line_limit(GUARD_LINES);
  localparam logic [CW-1:0]   CNT_LAST   = CW'(MAX_GRANT_CYC - 1);
  localparam logic [PW-1:0]   PTR_LAST   = PW'(N_REQ - 1);

  sched_state_t     state_reg, state_next;
  logic [N_REQ-1:0] gnt_reg, gnt_next;
  logic [PW-1:0]    ptr_reg, ptr_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [N_REQ-1:0] timeout_reg, timeout_next;
  logic             overrun_reg, overrun_next;
  logic             busy_reg;
  logic             vblnk_reg;
  logic             frame_tick_reg;

  logic [N_REQ-1:0] pick;
  logic             pick_valid;
  logic [PW-1:0]    pick_idx;
  logic             held_done;
  logic             held_req;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr (
    .req     (req),
    .pointer (ptr_reg),
    .pick    (pick),
    .valid   (pick_valid)
  );

  // Encode the one-hot pick and look only at the granted line's handshake.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
    held_done = |(done & gnt_reg);
    held_req  = |(req & gnt_reg);
  end

  // Next-state and grant bookkeeping; done beats revocation beats timeout.
  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    timeout_next = '0;
    overrun_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (vblnk) state_next = ST_ARB;
      end
      ST_ARB: begin
        if (!vblnk) begin
          state_next = ST_IDLE;
        end else if (pick_valid && (vcount < LINE_LIMIT)) begin
          state_next = ST_GRANT;
          gnt_next   = pick;
          ptr_next   = (pick_idx == PTR_LAST) ? '0 : pick_idx + PW'(1);
          cnt_next   = '0;
        end
      end
      ST_GRANT: begin
        if (held_done) begin
          gnt_next   = '0;
          state_next = vblnk ? ST_ARB : ST_IDLE;
        end else if (!vblnk) begin
          gnt_next     = '0;
          overrun_next = 1'b1;
          state_next   = ST_IDLE;
        end else if (!held_req) begin
          gnt_next   = '0;
          state_next = ST_ARB;
        end else if (cnt_reg == CNT_LAST) begin
          gnt_next     = '0;
          timeout_next = gnt_reg;
          state_next   = ST_ARB;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Grant, pointer and grant-age registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_reg  <= '0;
      busy_reg <= 1'b0;
      ptr_reg  <= '0;
      cnt_reg  <= '0;
    end else begin
      gnt_reg  <= gnt_next;
      busy_reg <= |gnt_next;
      ptr_reg  <= ptr_next;
      cnt_reg  <= cnt_next;
    end
  end

  // Single-cycle event pulses and vblnk edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_reg      <= 1'b0;
      frame_tick_reg <= 1'b0;
      timeout_reg    <= '0;
      overrun_reg    <= 1'b0;
    end else begin
      vblnk_reg      <= vblnk;
      frame_tick_reg <= vblnk & ~vblnk_reg;
      timeout_reg    <= timeout_next;
      overrun_reg    <= overrun_next;
    end
  end

  assign gnt         = gnt_reg;
  assign busy        = busy_reg;
  assign frame_tick  = frame_tick_reg;
  assign timeout_err = timeout_reg;
  assign overrun     = overrun_reg;

endmodule

// File: tb/tb_vblank_scheduler.sv
// Bench for vblank_scheduler: directed frame scenarios plus randomized
// blanking traffic, checked every cycle against a behavioural model.
module tb_vblank_scheduler;

  localparam int N     = 4;
  localparam int GUARD = 2;
  localparam int MAXC  = 4096;
  localparam int VMAX  = 628;

  logic          clk = 1'b0;
  logic          rst;
  logic          vblnk;
  logic [10:0]   vcount;
  logic [N-1:0]  req;
  logic [N-1:0]  done;
  logic [N-1:0]  gnt;
  logic          busy;
  logic          frame_tick;
  logic [N-1:0]  timeout_err;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  // Behavioural model: who holds the bus, how long, and whether the
  // scheduler is inside a blanking session.
  int           m_holder;
  int           m_age;
  int           m_start;
  bit           m_armed;
  bit           m_prev_v;
  logic [N-1:0] e_gnt;
  logic [N-1:0] e_tmo;
  bit           e_tick;
  bit           e_ovr;

  always #5 clk = ~clk;

  vblank_scheduler #(
    .N_REQ         (N),
    .GUARD_LINES   (GUARD),
    .MAX_GRANT_CYC (MAXC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vblnk       (vblnk),
    .vcount      (vcount),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .busy        (busy),
    .frame_tick  (frame_tick),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_holder = -1;
    m_age    = 0;
    m_start  = 0;
    m_armed  = 1'b0;
    m_prev_v = 1'b0;
    e_gnt    = '0;
    e_tmo    = '0;
    e_tick   = 1'b0;
    e_ovr    = 1'b0;
  endtask

  // One clock of the specified behaviour, using the inputs seen at the edge.
  task automatic model_step();
    int pick;
    e_tick   = vblnk && !m_prev_v;
    m_prev_v = vblnk;
    e_tmo    = '0;
    e_ovr    = 1'b0;
    if (m_holder >= 0) begin
      if (done[m_holder]) begin
        m_holder = -1;
        m_armed  = vblnk;
      end else if (!vblnk) begin
        m_holder = -1;
        m_armed  = 1'b0;
        e_ovr    = 1'b1;
      end else if (!req[m_holder]) begin
        m_holder = -1;
      end else if (m_age == MAXC - 1) begin
        e_tmo    = N'(1) << m_holder;
        m_holder = -1;
      end else begin
        m_age++;
      end
    end else if (!m_armed) begin
      m_armed = vblnk;
    end else if (!vblnk) begin
      m_armed = 1'b0;
    end else if (req != 0 && int'(vcount) < VMAX - GUARD) begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        if (pick < 0 && req[(m_start + k) % N]) pick = (m_start + k) % N;
      end
      m_holder = pick;
      m_age    = 0;
      m_start  = (pick + 1) % N;
      $display("grant: requester %0d at vcount %0d t=%0t", pick, vcount, $time);
    end
    e_gnt = (m_holder >= 0) ? (N'(1) << m_holder) : '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_val("gnt", 32'(gnt), 32'(e_gnt));
    check_val("busy", 32'(busy), 32'(|e_gnt));
    check_val("frame_tick", 32'(frame_tick), 32'(e_tick));
    check_val("timeout_err", 32'(timeout_err), 32'(e_tmo));
    check_val("overrun", 32'(overrun), 32'(e_ovr));
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_gnt"}, 32'(gnt), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_tick"}, 32'(frame_tick), 32'd0);
    check_val({tag, "_tmo"}, 32'(timeout_err), 32'd0);
    check_val({tag, "_ovr"}, 32'(overrun), 32'd0);
  endtask

  // Synchronous-looking reset entry from idle, released between edges.
  task automatic apply_reset();
    rst    = 1'b1;
    vblnk  = 1'b0;
    vcount = 11'd0;
    req    = '0;
    done   = '0;
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_zero("reset");
    end
    #2 rst = 1'b0;
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    #1;
    check_val("async_clear_gnt", 32'(gnt), 32'd0);
    check_val("async_clear_busy", 32'(busy), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_zero("reset_hold");
    #2 rst = 1'b0;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
      done[i] = ($urandom_range(0, 11) == 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 5000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] order [5];
    int           n;
    order[0] = 4'b0001;
    order[1] = 4'b0010;
    order[2] = 4'b0100;
    order[3] = 4'b1000;
    order[4] = 4'b0001;

    // Basic grant: tick one cycle after the rise, grant one cycle later.
    apply_reset();
    vcount = 11'd599;
    req    = 4'b0001;
    repeat (2) tick();
    vblnk  = 1'b1;
    vcount = 11'd600;
    tick();
    check_val("basic_tick", 32'(frame_tick), 32'd1);
    check_val("basic_nognt", 32'(gnt), 32'd0);
    tick();
    check_val("basic_gnt", 32'(gnt), 32'b0001);
    check_val("basic_tick_gone", 32'(frame_tick), 32'd0);
    done = 4'b0001;
    tick();
    done = '0;
    check_val("basic_release", 32'(gnt), 32'd0);
    req = '0;
    repeat (3) tick();

    // Round-robin order with one ARB cycle between grants.
    apply_reset();
    req    = 4'b1111;
    vblnk  = 1'b1;
    vcount = 11'd600;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      check_val("rr_order", 32'(gnt), 32'(order[k]));
      repeat (9) tick();
      done = order[k];
      tick();
      done = '0;
      check_val("rr_gap", 32'(gnt), 32'd0);
      tick();
    end
    req = '0;
    repeat (3) tick();

    // Timeout: grant held exactly MAXC cycles, then a one-cycle error pulse.
    apply_reset();
    req    = 4'b0100;
    vblnk  = 1'b1;
    vcount = 11'd600;
    tick();
    tick();
    check_val("tmo_gnt", 32'(gnt), 32'b0100);
    n = 1;
    while (n < MAXC + 100) begin
      tick();
      if (gnt != 4'b0100) break;
      n++;
    end
    check_val("tmo_len", 32'(n), 32'(MAXC));
    check_val("tmo_pulse", 32'(timeout_err), 32'b0100);
    tick();
    check_val("tmo_pulse_end", 32'(timeout_err), 32'd0);
    req = '0;
    repeat (3) tick();

    // Revocation at end of blanking, with and without a same-cycle done.
    apply_reset();
    for (int pass = 0; pass < 2; pass++) begin
      vblnk  = 1'b1;
      vcount = 11'd620;
      req    = 4'b0001;
      tick();
      tick();
      check_val("ovr_gnt", 32'(gnt), 32'b0001);
      for (int ln = 621; ln < VMAX; ln++) begin
        vcount = 11'(ln);
        repeat (2) tick();
      end
      vblnk  = 1'b0;
      vcount = 11'd0;
      done   = (pass == 1) ? 4'b0001 : 4'b0000;
      tick();
      done = '0;
      check_val("ovr_drop", 32'(gnt), 32'd0);
      check_val("ovr_pulse", 32'(overrun), (pass == 0) ? 32'd1 : 32'd0);
      tick();
      check_val("ovr_pulse_end", 32'(overrun), 32'd0);
      repeat (3) tick();
    end
    req = '0;

    // Guard band: a late request waits for the next frame.
    apply_reset();
    vblnk = 1'b1;
    for (int ln = 600; ln < 626; ln++) begin
      vcount = 11'(ln);
      tick();
    end
    req = 4'b0010;
    for (int ln = 626; ln < VMAX; ln++) begin
      vcount = 11'(ln);
      repeat (3) begin
        tick();
        check_val("guard_nognt", 32'(gnt), 32'd0);
      end
    end
    vblnk  = 1'b0;
    vcount = 11'd0;
    repeat (5) tick();
    vblnk  = 1'b1;
    vcount = 11'd600;
    tick();
    tick();
    check_val("guard_next_frame", 32'(gnt), 32'b0010);
    req = '0;
    repeat (3) tick();

    // Asynchronous reset mid-grant, released with blanking already active.
    apply_reset();
    vblnk  = 1'b1;
    vcount = 11'd605;
    req    = 4'b1000;
    tick();
    tick();
    check_val("arst_gnt_before", 32'(gnt), 32'b1000);
    async_reset_pulse();
    tick();
    check_val("arst_tick", 32'(frame_tick), 32'd1);
    tick();
    check_val("arst_tick_once", 32'(frame_tick), 32'd0);
    req = '0;
    repeat (3) tick();

    // Randomized frames: short active period, then 28 blanking lines.
    apply_reset();
    for (int f = 0; f < 30; f++) begin
      vblnk  = 1'b0;
      vcount = 11'($urandom_range(0, 599));
      repeat ($urandom_range(5, 20)) begin
        rand_inputs();
        tick();
      end
      for (int ln = 600; ln < VMAX; ln++) begin
        vblnk  = 1'b1;
        vcount = 11'(ln);
        repeat ($urandom_range(2, 10)) begin
          rand_inputs();
          if ($urandom_range(0, 1999) == 0) async_reset_pulse();
          tick();
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
